// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time round sequencer.
package reaction_pkg;

  localparam int unsigned MS_W      = 14;
  localparam int unsigned LFSR_W    = 8;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    GO    = 3'd2,
    DONE  = 3'd3,
    FOUL  = 3'd4
  } state_e;

  // One step of the 8-bit Fibonacci LFSR (shift left, taps 7,5,4,3).
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV enabled clocks.
module ms_tick #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear, wrap at CNT_MAX, hold while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == CNT_MAX);

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time game round sequencer: random hold-off, GO light, ms timing,
// foul and timeout handling, latched result for the display path.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned DELAY_MIN_MS = 1000,
  parameter int unsigned RAND_BITS    = 8,
  parameter int unsigned MAX_MS       = 9999
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            start,
  output logic            go_led,
  output logic            busy,
  output logic [MS_W-1:0] result_ms,
  output logic            result_valid,
  output logic            timeout,
  output logic            foul
);

  // Configuration sanity checks at elaboration.
  if (RAND_BITS > LFSR_W) begin : g_bad_rand_bits
    $error("reaction_ctrl: RAND_BITS must not exceed the LFSR width");
  end
  if (DELAY_MIN_MS + ((2 ** RAND_BITS) - 1) * 4 >= (2 ** MS_W)) begin : g_bad_delay
    $error("reaction_ctrl: maximum hold-off does not fit the ms counter");
  end
  if (MAX_MS < 1 || MAX_MS >= (2 ** MS_W)) begin : g_bad_max
    $error("reaction_ctrl: MAX_MS out of range for the ms counter");
  end
  if (DELAY_MIN_MS < 1) begin : g_bad_min
    $error("reaction_ctrl: DELAY_MIN_MS must be at least 1");
  end

  localparam logic [LFSR_W-1:0] RAND_MASK = LFSR_W'((9'(1) << RAND_BITS) - 9'(1));
  localparam logic [MS_W-1:0]   MAX_V     = MS_W'(MAX_MS);
  localparam logic [MS_W-1:0]   MAX_M1    = MS_W'(MAX_MS - 1);
  localparam logic [MS_W-1:0]   MIN_V     = MS_W'(DELAY_MIN_MS);

  state_e            state_q, state_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic [MS_W-1:0]   result_q, result_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              timeout_q, timeout_d;
  logic              go_led_q, go_led_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              foul_q, foul_d;
  logic              clear_c;
  logic              start_ev;
  logic              tick;
  logic [MS_W-1:0]   load_ms;

  // A start pulse only counts while enabled; it is not queued.
  assign start_ev = start && enable;
  assign load_ms  = MIN_V + (MS_W'(lfsr_q & RAND_MASK) << 2);

  ms_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_ms_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (clear_c),
    .tick   (tick)
  );

  // Round sequencing, counter update and next output values.
  always_comb begin
    state_d   = state_q;
    ms_d      = ms_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    clear_c   = 1'b0;
    lfsr_d    = lfsr_step(lfsr_q);

    case (state_q)
      IDLE, DONE: begin
        if (start_ev) begin
          state_d   = DELAY;
          ms_d      = load_ms;
          timeout_d = 1'b0;
          clear_c   = 1'b1;
        end
      end
      DELAY: begin
        if (start_ev) begin
          state_d = FOUL;
        end else if (tick) begin
          if (ms_q == MS_W'(1)) begin
            state_d = GO;
            ms_d    = '0;
            clear_c = 1'b1;
          end else begin
            ms_d = ms_q - MS_W'(1);
          end
        end
      end
      GO: begin
        if (start_ev) begin
          state_d   = DONE;
          result_d  = ms_q;
          timeout_d = 1'b0;
        end else if (tick) begin
          if (ms_q == MAX_M1) begin
            state_d   = DONE;
            ms_d      = MAX_V;
            result_d  = MAX_V;
            timeout_d = 1'b1;
          end else begin
            ms_d = ms_q + MS_W'(1);
          end
        end
      end
      FOUL: begin
        if (start_ev) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    go_led_d = (state_d == GO);
    busy_d   = (state_d == DELAY) || (state_d == GO);
    valid_d  = (state_d == DONE);
    foul_d   = (state_d == FOUL);
  end

  // State, counters, LFSR and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ms_q      <= '0;
      result_q  <= '0;
      lfsr_q    <= LFSR_SEED;
      timeout_q <= 1'b0;
      go_led_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      foul_q    <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      if (enable) begin
        state_q   <= state_d;
        ms_q      <= ms_d;
        result_q  <= result_d;
        timeout_q <= timeout_d;
        go_led_q  <= go_led_d;
        busy_q    <= busy_d;
        valid_q   <= valid_d;
        foul_q    <= foul_d;
      end
    end
  end

  assign go_led       = go_led_q;
  assign busy         = busy_q;
  assign result_ms    = result_q;
  assign result_valid = valid_q;
  assign timeout      = timeout_q;
  assign foul         = foul_q;

endmodule

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
- Round sequencer for the reaction-time lab game.
- Consumes the one-cycle start pulse from the button release-detect block and runs a full round: random hold-off, GO light, millisecond timing of the player's response, foul and timeout handling.
- Drives the GO LED and provides a latched result to the 7-segment display path.

Parameters:
- TICK_DIV, 50000: clk cycles per millisecond tick (50 MHz board clock).
- DELAY_MIN_MS, 1000: fixed part of the hold-off, in ms.
- RAND_BITS, 8: LFSR bits added to the hold-off. Random part = lfsr[RAND_BITS-1:0] << 2 ms. 0 gives a fixed delay.
- MAX_MS, 9999: response-time saturation value; also the timeout.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  when low: state, counters and prescaler are frozen and start is ignored. The LFSR keeps running.
- start  input  1  one-cycle pulse from the button release detector.
- go_led  output  1  high while in GO.
- busy  output  1  high in DELAY or GO.
- result_ms  output  14  latched reaction time in ms.
- result_valid  output  1  high in DONE.
- timeout  output  1  high in DONE when the round ended by saturation.
- foul  output  1  high in FOUL.

Behaviour:
- Reset: state IDLE. All outputs 0, result_ms = 0, prescaler = 0, ms counter = 0, LFSR = 8'hA5.
- All outputs are registered or decoded from registered state; no combinational path from start to any output.
- LFSR: 8-bit Fibonacci, shift left, feedback lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]. Advances every cycle not in reset.
- Prescaler: counts 0..TICK_DIV-1. tick = enable && (cnt == TICK_DIV-1). Cleared to 0 on every transition into DELAY or GO, so the first ms is full length.
- IDLE:
  - start -> DELAY.
  - Load ms counter with DELAY_MIN_MS + (lfsr[RAND_BITS-1:0] << 2), using LFSR value at the start cycle.
  - Clear result_valid, timeout, foul.
- DELAY:
  - Each tick decrements the ms counter.
  - Tick with counter == 1 -> GO, ms counter := 0.
  - start -> FOUL.
  - start and final tick in the same cycle -> FOUL (start wins).
- GO:
  - Each tick increments the ms counter.
  - start -> DONE with result_ms := current count. If a tick lands in the same cycle, the pre-increment value is used.
  - Tick that would make count == MAX_MS -> DONE, result_ms := MAX_MS, timeout := 1.
  - start on that same cycle -> DONE with timeout := 0 and result_ms = count.
- DONE:
  - result_ms held; result_valid = 1.
  - start -> DELAY with a new load (new round). result_valid, timeout clear on entry to DELAY.
- FOUL:
  - foul = 1.
  - start -> IDLE; foul clears.
- Latency: with RAND_BITS = 0, go_led rises exactly DELAY_MIN_MS*TICK_DIV clocks after the edge that samples start.
- enable low: no state change, ticks suppressed, prescaler held, start dropped (not queued).
- rst mid-round: returns to reset state at the next edge and discards any result.
- Widths:
  - ms counter is 14 bits.
  - DELAY_MIN_MS + (2^RAND_BITS - 1)*4 must be < 16384; checked by elaboration assertion.
  - Prescaler width = $clog2(TICK_DIV).

Decomposition:
- Package reaction_pkg:
  - state enum: IDLE, DELAY, GO, DONE, FOUL.
  - MS_W = 14.
  - LFSR_SEED = 8'hA5.
- Sub-module ms_tick: prescaler with clk, rst, enable, clear inputs and a tick output; parameter TICK_DIV.
- LFSR and FSM stay in reaction_ctrl.

Test Plan (TICK_DIV=4, DELAY_MIN_MS=3, RAND_BITS=0, MAX_MS=20 unless stated):
1. Reset, hold rst 3 cycles -> all outputs 0, busy 0; start while rst=1 has no effect.
2. start at edge k -> busy from k, go_led rises after edge k+12; start 22 cycles later (5 ticks elapsed) -> result_ms=5, result_valid=1, go_led=0.
3. start during DELAY at edge k+6 -> foul=1, go_led never asserts; next start -> IDLE, foul=0.
4. No response in GO -> after 20 ticks result_ms=20, timeout=1, result_valid=1; start -> new DELAY, flags clear.
5. enable=0 for 40 cycles mid-GO, start pulsed during that window -> state and count frozen, pulse ignored; after re-enable, result counts only enabled ticks.
6. RAND_BITS=8, bench LFSR model from seed A5 -> go_led delay matches (3 + model[7:0]*4)*4 cycles; rst asserted mid-GO -> all outputs 0 next cycle.
